key_schedule: RTL and testbench



---
 rtl/key_schedule_pkg.sv | 66 ++++++
 rtl/key_schedule_sub_word.sv | 17 +
 rtl/key_schedule.sv | 104 ++++++++++
 tb/tb_key_schedule.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_schedule_pkg.sv
// Shared AES-128 key schedule definitions: sizes, FSM encodings, S-box, Rcon
// and column/byte slicing helpers.
package key_schedule_pkg;

   localparam int unsigned AES_NK     = 4;
   localparam int unsigned AES_NR_128 = 10;

   typedef logic [31:0] word_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // AES forward S-box, entry 0 in the most significant byte
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
   endfunction

   // Round constant for round i (1..10); out-of-range indices give zero
   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Column c of a 128-bit block (column 0 in the top bits)
   function automatic word_t col(input logic [127:0] blk, input int unsigned c);
      return blk[127 - 32*c -: 32];
   endfunction

   // Byte b of a word (byte 0 in the top bits)
   function automatic logic [7:0] get_byte(input word_t w, input int unsigned b);
      return w[31 - 8*b -: 8];
   endfunction

endpackage

// File: rtl/key_schedule_sub_word.sv
// SubWord: AES S-box applied independently to each byte of a 32-bit word.
module key_schedule_sub_word
   import key_schedule_pkg::*;
(
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // One S-box lookup per byte lane
   always_comb begin
      dout = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         dout[31 - 8*b -: 8] = sbox(get_byte(din, b));
      end
   end

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: round key register updated in place, one
// round per accepted handshake, round keys 0..NR streamed over valid/ready.
module key_schedule
   import key_schedule_pkg::*;
#(
   parameter int unsigned NR = AES_NR_128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [3:0]   rk_round,
   output logic [127:0] rk_data,
   output logic         busy
);

   localparam logic [3:0] NR_LAST = 4'(NR);

   logic [0:0]   state_q, state_d;
   logic [127:0] rk_data_q, rk_data_d;
   logic [3:0]   rk_round_q, rk_round_d;

   word_t        w [AES_NK];
   word_t        n [AES_NK];
   word_t        rot_w3;
   word_t        sub_w3;
   word_t        t;
   logic [127:0] next_key;

   // Outputs decoded from the FSM state and key registers
   always_comb begin
      key_ready = (state_q == ST_IDLE);
      rk_valid  = (state_q == ST_RUN);
      busy      = (state_q == ST_RUN);
      rk_round  = rk_round_q;
      rk_data   = rk_data_q;
   end

   // RotWord of the last column feeding the S-box stage
   always_comb begin
      for (int unsigned c = 0; c < AES_NK; c++) begin
         w[c] = col(rk_data_q, c);
      end
      rot_w3 = {w[3][23:0], w[3][31:24]};
   end

   key_schedule_sub_word u_sub_word (
      .din  (rot_w3),
      .dout (sub_w3)
   );

   // Next round key: chained XOR across the four columns
   always_comb begin
      t    = sub_w3 ^ {rcon(rk_round_q + 4'd1), 24'h000000};
      n[0] = w[0] ^ t;
      for (int unsigned c = 1; c < AES_NK; c++) begin
         n[c] = w[c] ^ n[c-1];
      end
      next_key = {n[0], n[1], n[2], n[3]};
   end

   // FSM and key register next-state
   always_comb begin
      state_d    = state_q;
      rk_data_d  = rk_data_q;
      rk_round_d = rk_round_q;
      case (state_q)
         ST_IDLE: begin
            if (key_valid) begin
               rk_data_d  = key;
               rk_round_d = 4'd0;
               state_d    = ST_RUN;
            end
         end
         default: begin
            if (rk_ready) begin
               if (rk_round_q == NR_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  rk_data_d  = next_key;
                  rk_round_d = rk_round_q + 4'd1;
               end
            end
         end
      endcase
   end

   // State registers, asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rk_data_q  <= '0;
         rk_round_q <= '0;
      end else begin
         state_q    <= state_d;
         rk_data_q  <= rk_data_d;
         rk_round_q <= rk_round_d;
      end
   end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: FIPS-197 vectors, stalls, key offered
// during RUN, mid-schedule reset and an NR=1 build.
module tb_key_schedule;

   logic         clk;
   logic         rst_n;

   logic         key_valid, key_ready, rk_valid, rk_ready, busy;
   logic [127:0] key, rk_data;
   logic [3:0]   rk_round;

   logic         key_valid1, key_ready1, rk_valid1, rk_ready1, busy1;
   logic [127:0] key1, rk_data1;
   logic [3:0]   rk_round1;

   int n_checks = 0;
   int n_errors = 0;

   logic [127:0] exp_k1 [11];
   logic [127:0] exp_rk [11];
   logic [10:0]  exp_mask;

   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

   key_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_round  (rk_round),
      .rk_data   (rk_data),
      .busy      (busy)
   );

   key_schedule #(.NR(1)) dut_nr1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid1),
      .key_ready (key_ready1),
      .key       (key1),
      .rk_valid  (rk_valid1),
      .rk_ready  (rk_ready1),
      .rk_round  (rk_round1),
      .rk_data   (rk_data1),
      .busy      (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a key and hold it until accepted (bounded)
   task automatic offer_key(input logic [127:0] k);
      int waited = 0;
      key       = k;
      key_valid = 1'b1;
      while (!key_ready && waited < 50) begin
         tick();
         waited++;
      end
      check("offer_key_ready", 128'(key_ready), 128'd1);
      tick();
      key_valid = 1'b0;
   endtask

   // Consume rounds 0..10, optionally stalling, checking each against exp_rk
   task automatic drain(input bit stall, input bit timed);
      int           cycles = 0;
      logic [127:0] hold_d;
      logic [3:0]   hold_r;
      for (int r = 0; r <= 10; r++) begin
         check("rk_valid", 128'(rk_valid), 128'd1);
         check("busy", 128'(busy), 128'd1);
         check("key_ready_run", 128'(key_ready), 128'd0);
         check($sformatf("rk_round_%0d", r), 128'(rk_round), 128'(r));
         if (exp_mask[r]) check($sformatf("rk_data_%0d", r), rk_data, exp_rk[r]);
         if (stall) begin
            for (int s = 0; s < 8 && $urandom_range(1, 0) == 0; s++) begin
               rk_ready = 1'b0;
               hold_d   = rk_data;
               hold_r   = rk_round;
               tick();
               cycles++;
               check("stall_data", rk_data, hold_d);
               check("stall_round", 128'(rk_round), 128'(hold_r));
               check("stall_valid", 128'(rk_valid), 128'd1);
            end
         end
         rk_ready = 1'b1;
         tick();
         cycles++;
         rk_ready = 1'b0;
      end
      if (timed) check("idle_latency", 128'(cycles), 128'd11);
      check("end_key_ready", 128'(key_ready), 128'd1);
      check("end_rk_valid", 128'(rk_valid), 128'd0);
      check("end_busy", 128'(busy), 128'd0);
      check("end_rk_round", 128'(rk_round), 128'd10);
      if (exp_mask[10]) check("end_rk_data_hold", rk_data, exp_rk[10]);
   endtask

   initial begin
      exp_k1[0]  = KEY1;
      exp_k1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_k1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_k1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_k1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_k1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_k1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_k1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_k1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_k1[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_k1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst_n      = 1'b0;
      key_valid  = 1'b0;
      key        = '0;
      rk_ready   = 1'b0;
      key_valid1 = 1'b0;
      key1       = '0;
      rk_ready1  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_key_ready", 128'(key_ready), 128'd1);
      check("rst_rk_valid", 128'(rk_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_rk_round", 128'(rk_round), 128'd0);
      check("rst_rk_data", rk_data, 128'd0);

      // rk_ready while idle does nothing
      rk_ready = 1'b1;
      repeat (2) tick();
      rk_ready = 1'b0;
      check("idle_ready_valid", 128'(rk_valid), 128'd0);
      check("idle_ready_round", 128'(rk_round), 128'd0);
      check("idle_ready_data", rk_data, 128'd0);

      // Test 1: FIPS-197 key, no backpressure
      exp_rk   = exp_k1;
      exp_mask = '1;
      offer_key(KEY1);
      drain(1'b0, 1'b1);

      // Test 2: sequential-byte key
      exp_rk     = exp_k1;
      exp_rk[0]  = KEY2;
      exp_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      exp_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      exp_mask   = 11'b100_0000_0011;
      offer_key(KEY2);
      drain(1'b0, 1'b1);

      // Test 3: random stalls
      exp_rk   = exp_k1;
      exp_mask = '1;
      offer_key(KEY1);
      drain(1'b1, 1'b0);

      // Test 4: second key held valid throughout RUN
      offer_key(KEY1);
      key       = KEY2;
      key_valid = 1'b1;
      drain(1'b0, 1'b0);
      tick();
      key_valid = 1'b0;
      exp_rk     = exp_k1;
      exp_rk[0]  = KEY2;
      exp_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      exp_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      exp_mask   = 11'b100_0000_0011;
      drain(1'b0, 1'b0);

      // Test 5: asynchronous reset at round 5
      exp_rk   = exp_k1;
      exp_mask = '1;
      offer_key(KEY1);
      rk_ready = 1'b1;
      for (int i = 0; i < 20 && rk_round != 4'd5; i++) tick();
      rk_ready = 1'b0;
      check("pre_reset_round", 128'(rk_round), 128'd5);
      check("pre_reset_data", rk_data, exp_k1[5]);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 128'(rk_valid), 128'd0);
      check("async_rst_busy", 128'(busy), 128'd0);
      check("async_rst_round", 128'(rk_round), 128'd0);
      check("async_rst_data", rk_data, 128'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_key_ready", 128'(key_ready), 128'd1);
      check("post_rst_valid", 128'(rk_valid), 128'd0);
      offer_key(KEY1);
      drain(1'b0, 1'b1);

      // Test 6: NR=1 build
      check("nr1_rst_key_ready", 128'(key_ready1), 128'd1);
      key1       = KEY1;
      key_valid1 = 1'b1;
      tick();
      key_valid1 = 1'b0;
      rk_ready1  = 1'b1;
      check("nr1_r0_valid", 128'(rk_valid1), 128'd1);
      check("nr1_r0_round", 128'(rk_round1), 128'd0);
      check("nr1_r0_data", rk_data1, KEY1);
      tick();
      check("nr1_r1_valid", 128'(rk_valid1), 128'd1);
      check("nr1_r1_round", 128'(rk_round1), 128'd1);
      check("nr1_r1_data", rk_data1, exp_k1[1]);
      tick();
      rk_ready1 = 1'b0;
      check("nr1_end_valid", 128'(rk_valid1), 128'd0);
      check("nr1_end_busy", 128'(busy1), 128'd0);
      check("nr1_end_key_ready", 128'(key_ready1), 128'd1);
      check("nr1_end_round", 128'(rk_round1), 128'd1);
      check("nr1_end_data", rk_data1, exp_k1[1]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
